// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs and stage-control outputs of the pipeline stall/flush controller
interface pipeline_ctrl_if #(parameter int XLEN = 32, parameter int CNT_W = 16);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic [XLEN-1:0]  ex_target;
  logic             imem_ready;
  logic             dmem_stall;
  logic             pc_en;
  logic             pc_sel;
  logic [XLEN-1:0]  redirect_pc;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_flush;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] redirect_count;
  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, ex_target, imem_ready, dmem_stall,
    input  pc_en, pc_sel, redirect_pc, if_id_en, if_id_flush, id_ex_en,
           id_ex_flush, stall_cycles, redirect_count
  );
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, ex_target, imem_ready, dmem_stall,
    output pc_en, pc_sel, redirect_pc, if_id_en, if_id_flush, id_ex_en,
           id_ex_flush, stall_cycles, redirect_count
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush arbitration for the 5-stage pipeline, holding a taken branch until the in-flight fetch completes
module pipeline_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset_n,
  pipeline_ctrl_if.slave ctl_if
);
  typedef enum logic {RUN, PEND_REDIR} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0] stall_q, stall_d, redir_q, redir_d;
  logic load_use, redir;
  assign load_use = ctl_if.ex_mem_read && (ctl_if.ex_rd != 5'd0) &&
                    ((ctl_if.id_uses_rs1 && ctl_if.id_rs1 == ctl_if.ex_rd) ||
                     (ctl_if.id_uses_rs2 && ctl_if.id_rs2 == ctl_if.ex_rd));
  always_comb begin
    state_d              = state_q;
    pend_pc_d            = pend_pc_q;
    redir                = 1'b0;
    ctl_if.pc_en         = 1'b1;
    ctl_if.pc_sel        = 1'b0;
    ctl_if.if_id_en      = 1'b1;
    ctl_if.if_id_flush   = 1'b0;
    ctl_if.id_ex_en      = 1'b1;
    ctl_if.id_ex_flush   = 1'b0;
    ctl_if.redirect_pc   = state_q == RUN ? ctl_if.ex_target : pend_pc_q;
    if (!reset_n) begin
      state_d            = RUN;
      pend_pc_d          = '0;
      ctl_if.pc_en       = 1'b0;
      ctl_if.if_id_en    = 1'b0;
      ctl_if.id_ex_en    = 1'b0;
      ctl_if.redirect_pc = '0;
    end else if (ctl_if.dmem_stall) begin
      ctl_if.pc_en       = 1'b0;
      ctl_if.if_id_en    = 1'b0;
      ctl_if.id_ex_en    = 1'b0;
    end else if (state_q == PEND_REDIR || ctl_if.ex_branch_taken) begin
      // the redirect can only be issued once the current fetch has returned
      ctl_if.if_id_flush = 1'b1;
      ctl_if.id_ex_flush = 1'b1;
      ctl_if.pc_en       = ctl_if.imem_ready;
      ctl_if.pc_sel      = ctl_if.imem_ready;
      redir              = ctl_if.imem_ready;
      state_d            = ctl_if.imem_ready ? RUN : PEND_REDIR;
      pend_pc_d          = state_q == RUN ? ctl_if.ex_target : pend_pc_q;
    end else if (load_use) begin
      ctl_if.pc_en       = 1'b0;
      ctl_if.if_id_en    = 1'b0;
      ctl_if.id_ex_flush = 1'b1;
    end else if (!ctl_if.imem_ready) begin
      ctl_if.pc_en       = 1'b0;
      ctl_if.if_id_flush = 1'b1;
    end
    stall_d = stall_q + {{(CNT_W-1){1'b0}}, !ctl_if.pc_en && !(&stall_q)};
    redir_d = redir_q + {{(CNT_W-1){1'b0}}, redir && !(&redir_q)};
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RUN;
      pend_pc_q <= '0;
      stall_q   <= '0;
      redir_q   <= '0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
      stall_q   <= stall_d;
      redir_q   <= redir_d;
    end
  end
  assign ctl_if.stall_cycles   = stall_q;
  assign ctl_if.redirect_count = redir_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed vectors with a scoreboard queue checked by a negedge monitor
module tb_pipeline_ctrl;
  localparam int XLEN = 32;
  localparam int CNT_W = 4;
  typedef struct packed {
    logic [5:0]       ctl;
    logic [XLEN-1:0]  rpc;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] rc;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int tests = 0;
  int fails = 0;
  exp_t exp_q[$];
  string name_q[$];
  pipeline_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
  pipeline_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (.clk(clk), .reset_n(reset_n), .ctl_if(bus));
  always #5 clk = ~clk;
  // ctl bit order: pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush
  localparam logic [5:0] NORM = 6'b101010, LU = 6'b000011, REDIR = 6'b111111,
                         WAIT = 6'b001111, FRZ = 6'b000000, NRDY = 6'b001110;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      string n;
      logic [5:0] act_ctl;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      act_ctl = {bus.pc_en, bus.pc_sel, bus.if_id_en, bus.if_id_flush, bus.id_ex_en, bus.id_ex_flush};
      tests++;
      if (act_ctl !== e.ctl || bus.redirect_pc !== e.rpc) begin
        fails++;
        $display("FAIL %s ctl: got ctl=%b pc=%h, want ctl=%b pc=%h", n, act_ctl, bus.redirect_pc, e.ctl, e.rpc);
      end
      tests++;
      if (bus.stall_cycles !== e.sc || bus.redirect_count !== e.rc) begin
        fails++;
        $display("FAIL %s cnt: got stall=%0d redir=%0d, want stall=%0d redir=%0d", n, bus.stall_cycles, bus.redirect_count, e.sc, e.rc);
      end
    end
  end
  task automatic drive(input logic br, input logic [XLEN-1:0] tgt, input logic imr, input logic dms,
                       input logic mr, input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2);
    bus.ex_branch_taken = br;
    bus.ex_target = tgt;
    bus.imem_ready = imr;
    bus.dmem_stall = dms;
    bus.ex_mem_read = mr;
    bus.ex_rd = rd;
    bus.id_rs1 = rs1;
    bus.id_uses_rs1 = u1;
    bus.id_rs2 = rs2;
    bus.id_uses_rs2 = u2;
  endtask
  task automatic expect_out(input string n, input logic [5:0] ctl, input logic [XLEN-1:0] rpc,
                            input int sc, input int rc);
    exp_q.push_back('{ctl: ctl, rpc: rpc, sc: CNT_W'(sc), rc: CNT_W'(rc)});
    name_q.push_back(n);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    idle();
    repeat (2) step();
    drive(1, 32'h55, 1, 0, 0, 0, 0, 0, 0, 0);
    expect_out("reset", FRZ, 0, 0, 0); step();
    reset_n = 1'b1;
    idle(); expect_out("idle", NORM, 0, 0, 0); step();
    drive(0, 0, 1, 0, 1, 5, 5, 1, 0, 0); expect_out("loaduse", LU, 0, 0, 0); step();
    idle(); expect_out("after_lu", NORM, 0, 1, 0); step();
    drive(1, 32'h100, 1, 0, 0, 0, 0, 0, 0, 0); expect_out("redir_imm", REDIR, 32'h100, 1, 0); step();
    idle(); expect_out("after_redir", NORM, 0, 1, 1); step();
    drive(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("pend1", WAIT, 32'h200, 1, 1); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("pend2", WAIT, 32'h200, 2, 1); step();
    expect_out("pend3", WAIT, 32'h200, 3, 1); step();
    bus.imem_ready = 1'b1; expect_out("pend_go", REDIR, 32'h200, 4, 1); step();
    idle(); expect_out("after_pend", NORM, 0, 4, 2); step();
    drive(1, 32'h300, 1, 1, 1, 5, 5, 1, 0, 0); expect_out("prio_freeze", FRZ, 32'h300, 4, 2); step();
    bus.dmem_stall = 1'b0; expect_out("prio_redir", REDIR, 32'h300, 5, 2); step();
    drive(0, 0, 1, 0, 1, 0, 0, 1, 0, 0); expect_out("lu_x0", NORM, 0, 5, 3); step();
    drive(0, 0, 0, 0, 1, 7, 0, 0, 7, 1); expect_out("lu_nrdy", LU, 0, 5, 3); step();
    drive(0, 0, 1, 0, 1, 7, 0, 0, 7, 0); expect_out("lu_unused", NORM, 0, 6, 3); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("nrdy", NRDY, 0, 6, 3); step();
    idle(); expect_out("idle2", NORM, 0, 7, 3); step();
    drive(1, 32'h400, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("pend_rst1", WAIT, 32'h400, 7, 3); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("async_rst", FRZ, 0, 0, 0);
    #2 reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    idle(); expect_out("post_rst", NORM, 0, 0, 0); step();
    expect_out("post_rst2", NORM, 0, 0, 0); step();
    bus.imem_ready = 1'b0;
    repeat (20) step();
    expect_out("sat_stall", NRDY, 0, 15, 0); step();
    idle(); expect_out("sat_hold", NORM, 0, 15, 0); step();
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish before 100000");
    $fatal(1, "timeout");
  end
endmodule
